mnk_game: RTL and testbench
===========================

MNK_GAME -- requirements
Module: mnk_game

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The module SHALL have parameter N, default 3, meaning board side length; legal range is 3..8.
REQ-003 The module SHALL have parameter K, default N, meaning the in-a-row length needed to win; legal range is 3..N.
REQ-004 The module SHALL have parameter HOLD_CYCLES, default 255, meaning the number of cycles a result state is held before the board clears; minimum is 1.
REQ-005 The module SHALL have localparam CELLS = N*N.
REQ-006 The module SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The module SHALL have port select, input, 1 bit: a move-submit strobe that is sampled only in PLAY.
REQ-009 The module SHALL have port move, input, CELLS bits: one-hot target cell, where cell index = row*N+col and cell 0 is top-left.
REQ-010 The module SHALL have port board_o, output, 2*CELLS bits: the cell codes, with cell i at bits [2i+1:2i].
REQ-011 The module SHALL have port cur_player, output, 1 bit: 0 for P1 and 1 for P2.
REQ-012 The module SHALL have port state_o, output, 3 bits: the encoded FSM state.
REQ-013 The module SHALL have port winner_o, output, 2 bits: 00 none, 01 P1, 10 P2, 11 tie.
REQ-014 The module SHALL have port move_ok, output, 1 bit: a 1-cycle pulse on an accepted move.
REQ-015 The module SHALL have port move_err, output, 1 bit: a 1-cycle pulse on a rejected move.

Function
REQ-016 Cell codes SHALL be 00 empty, 01 P1 and 10 P2; code 11 SHALL never be written.
REQ-017 The FSM states SHALL be PLAY, CHECK_MOVE, CHECK_WIN, P1_WIN, P2_WIN, TIE and CLEAR.
REQ-018 In PLAY with select=1, the block SHALL latch move into loc and enter CHECK_MOVE on the next cycle; select SHALL be ignored in every other state.
REQ-019 In CHECK_MOVE, the move SHALL be valid only if loc is exactly one-hot and the target cell is 00.
REQ-020 For a valid move, the block SHALL write the cell with the cur_player code, increment move_cnt, pulse move_ok, clear dir to 0 and go to CHECK_WIN.
REQ-021 For an invalid move (zero-hot, multi-hot or occupied cell), the block SHALL pulse move_err, leave the board and player unchanged and return to PLAY.
REQ-022 CHECK_WIN SHALL examine one direction per cycle, in the order dir 0 horizontal, 1 vertical, 2 diagonal down-right, 3 anti-diagonal down-left.
REQ-023 The run length SHALL be 1 plus the number of consecutive matching cells from loc in the +dir direction plus those in the -dir direction.
REQ-024 Each run SHALL stop at a board edge, with no wrap from column N-1 to column 0 of the next row and no wrap between rows.
REQ-025 If run >= K, the FSM SHALL go to P1_WIN or P2_WIN according to the mark just placed, and the remaining directions SHALL be skipped.
REQ-026 If dir 3 completes with no win and move_cnt == CELLS, the FSM SHALL go to TIE.
REQ-027 If dir 3 completes with no win and move_cnt < CELLS, the block SHALL toggle cur_player and return to PLAY.
REQ-028 The latency from select to the next PLAY SHALL be at most 6 cycles: 1 for latch, 1 for check_move and up to 4 for check_win.
REQ-029 On entry to P1_WIN, P2_WIN or TIE, winner_o SHALL be set and held; a hold counter SHALL count HOLD_CYCLES cycles and the FSM SHALL then enter CLEAR.
REQ-030 CLEAR SHALL last 1 cycle, set all cells to 00, move_cnt=0, cur_player=0 and winner_o=00, and then go to PLAY.
REQ-031 move_cnt width SHALL be $clog2(CELLS+1); the hold counter width SHALL be $clog2(HOLD_CYCLES+1); neither SHALL wrap.
REQ-032 All outputs SHALL be registered; board_o SHALL show the new mark in the first CHECK_WIN cycle.

Reset
REQ-033 rst SHALL take priority over all FSM activity, including a reset in the middle of CHECK_WIN or during a hold.
REQ-034 On rst the block SHALL enter PLAY on the next edge with board all 00, cur_player=0, winner_o=00, move_ok=move_err=0, move_cnt=0 and the hold counter at 0.
REQ-035 select asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-036 Package mnk_pkg SHALL hold the state enum (3-bit), the cell-code constants, the winner codes and the direction enum.
REQ-037 One combinational sub-module, mnk_run_len, SHALL be used with inputs board, loc index, dir and mark, parameters N and K, and output hit (run >= K).
REQ-038 The top level SHALL contain the FSM, the board register, the counters and the pulse generation.

Verification
REQ-039 Scenario 1: with N=3 and K=3, P1 plays 0,1,2 and P2 plays 3,4, interleaved -> P1_WIN after the 5th move, winner_o=01, and CLEAR after HOLD_CYCLES cycles.
REQ-040 Scenario 2: with N=3, a move to an occupied cell and a move of 0 -> move_err pulses, board_o is unchanged and cur_player is unchanged.
REQ-041 Scenario 3: with N=3, the 9-move draw 0,1,2,4,3,5,7,6,8 -> TIE, winner_o=11, move_cnt=9.
REQ-042 Scenario 4: with N=5 and K=4, P1 plays 4,5,6,7, indices that would wrap across rows -> no win.
REQ-043 Scenario 4 (continued): P2 plays 20,16,12,8 on the anti-diagonal -> P2_WIN.
REQ-044 Scenario 5: rst asserted in the 2nd CHECK_WIN cycle and also during a hold -> PLAY on the next edge, all outputs at their reset values.

Source files
------------

// File: rtl/mnk_pkg.sv
// Shared types and encodings for the m,n,k game engine: FSM states, cell codes,
// winner codes and scan directions.
package mnk_pkg;

  typedef enum logic [2:0] {
    ST_PLAY       = 3'd0,
    ST_CHECK_MOVE = 3'd1,
    ST_CHECK_WIN  = 3'd2,
    ST_P1_WIN     = 3'd3,
    ST_P2_WIN     = 3'd4,
    ST_TIE        = 3'd5,
    ST_CLEAR      = 3'd6
  } state_e;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  function automatic logic [1:0] player_code(input logic player);
    return player ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/mnk_run_len.sv
// Combinational run-length probe: counts same-mark cells through loc along one
// direction (both senses, clipped at board edges) and flags a run of at least K.
module mnk_run_len
  import mnk_pkg::*;
#(
  parameter int N = 3,
  parameter int K = N
) (
  input  logic [2*N*N-1:0]         board_i,
  input  logic [$clog2(N*N)-1:0]   loc_idx_i,
  input  dir_e                     dir_i,
  input  logic [1:0]               mark_i,
  output logic                     hit_o
);

  localparam int CELLS = N * N;

  logic [CELLS-1:0] match_s;
  int               row_s;
  int               col_s;
  int               dr_s;
  int               dc_s;
  int               run_s;

  for (genvar g = 0; g < CELLS; g++) begin : g_match
    assign match_s[g] = (board_i[2*g +: 2] == mark_i);
  end

  // Walks from (row,col) in steps of (dr,dc), stopping at the first mismatch or edge.
  function automatic int count_steps(input logic [CELLS-1:0] m, input int row, input int col,
                                     input int dr, input int dc);
    int  n;
    int  r;
    int  c;
    int  idx;
    bit  go;
    bit  inb;
    bit  step_ok;
    n  = 32'sd0;
    go = 1'b1;
    for (int s = 1; s < N; s++) begin
      r       = row + s * dr;
      c       = col + s * dc;
      inb     = (r >= 32'sd0) && (r < N) && (c >= 32'sd0) && (c < N);
      idx     = inb ? (r * N + c) : 32'sd0;
      step_ok = go && inb && m[idx];
      n       = n + (step_ok ? 32'sd1 : 32'sd0);
      go      = step_ok;
    end
    return n;
  endfunction

  // Direction decode and two-sided run measurement.
  always_comb begin
    row_s = int'(loc_idx_i) / N;
    col_s = int'(loc_idx_i) % N;
    dr_s  = 32'sd0;
    dc_s  = 32'sd1;
    case (dir_i)
      DIR_H: begin dr_s = 32'sd0; dc_s = 32'sd1;  end
      DIR_V: begin dr_s = 32'sd1; dc_s = 32'sd0;  end
      DIR_D: begin dr_s = 32'sd1; dc_s = 32'sd1;  end
      DIR_A: begin dr_s = 32'sd1; dc_s = -32'sd1; end
      default: begin dr_s = 32'sd0; dc_s = 32'sd1; end
    endcase
    run_s = 32'sd1 + count_steps(match_s, row_s, col_s, dr_s, dc_s)
                   + count_steps(match_s, row_s, col_s, -dr_s, -dc_s);
    hit_o = (run_s >= K);
  end

endmodule

// File: rtl/mnk_game.sv
// Two-player m,n,k game engine: move validation, per-direction win scan,
// result hold and board clear, all outputs registered.
module mnk_game
  import mnk_pkg::*;
#(
  parameter int N           = 3,
  parameter int K           = N,
  parameter int HOLD_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 select,
  input  logic [N*N-1:0]       move,
  output logic [2*N*N-1:0]     board_o,
  output logic                 cur_player,
  output logic [2:0]           state_o,
  output logic [1:0]           winner_o,
  output logic                 move_ok,
  output logic                 move_err
);

  localparam int CELLS = N * N;
  localparam int IDXW  = $clog2(CELLS);
  localparam int CNTW  = $clog2(CELLS + 1);
  localparam int HOLDW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNTW-1:0]  CNT_FULL  = CNTW'(CELLS);
  localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(32'd1);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_CYCLES - 1);
  localparam logic [HOLDW-1:0] HOLD_ONE  = HOLDW'(32'd1);
  localparam logic [CELLS-1:0] LOC_ONE   = CELLS'(32'd1);

  state_e             state_q,    state_d;
  logic [2*CELLS-1:0] board_q,    board_d;
  logic [CELLS-1:0]   loc_q,      loc_d;
  logic [IDXW-1:0]    loc_idx_q,  loc_idx_d;
  logic               player_q,   player_d;
  logic [CNTW-1:0]    move_cnt_q, move_cnt_d;
  logic [HOLDW-1:0]   hold_q,     hold_d;
  dir_e               dir_q,      dir_d;
  logic [1:0]         winner_q,   winner_d;
  logic               ok_q,       ok_d;
  logic               err_q,      err_d;

  logic [CELLS-1:0]   occupied_s;
  logic [IDXW-1:0]    loc_enc_s;
  logic [2*CELLS-1:0] board_wr_s;
  logic               onehot_s;
  logic               move_valid_s;
  logic               hit_s;

  for (genvar g = 0; g < CELLS; g++) begin : g_occ
    assign occupied_s[g] = |board_q[2*g +: 2];
  end

  // Move decode: one-hot test, OR-encoder (exact for one-hot) and candidate board.
  always_comb begin
    onehot_s     = (loc_q != {CELLS{1'b0}}) && ((loc_q & (loc_q - LOC_ONE)) == {CELLS{1'b0}});
    move_valid_s = onehot_s && ((loc_q & occupied_s) == {CELLS{1'b0}});
    loc_enc_s    = {IDXW{1'b0}};
    board_wr_s   = board_q;
    for (int i = 0; i < CELLS; i++) begin
      loc_enc_s            = loc_enc_s | (IDXW'(i) & {IDXW{loc_q[i]}});
      board_wr_s[2*i +: 2] = loc_q[i] ? player_code(player_q) : board_q[2*i +: 2];
    end
  end

  mnk_run_len #(
    .N (N),
    .K (K)
  ) u_run_len (
    .board_i   (board_q),
    .loc_idx_i (loc_idx_q),
    .dir_i     (dir_q),
    .mark_i    (player_code(player_q)),
    .hit_o     (hit_s)
  );

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    loc_d      = loc_q;
    loc_idx_d  = loc_idx_q;
    player_d   = player_q;
    move_cnt_d = move_cnt_q;
    hold_d     = hold_q;
    dir_d      = dir_q;
    winner_d   = winner_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (select) begin
          loc_d   = move;
          state_d = ST_CHECK_MOVE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_CHECK_MOVE: begin
        if (move_valid_s) begin
          board_d    = board_wr_s;
          loc_idx_d  = loc_enc_s;
          move_cnt_d = (move_cnt_q < CNT_FULL) ? (move_cnt_q + CNT_ONE) : move_cnt_q;
          ok_d       = 1'b1;
          dir_d      = DIR_H;
          state_d    = ST_CHECK_WIN;
        end else begin
          err_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_CHECK_WIN: begin
        if (hit_s) begin
          state_d  = player_q ? ST_P2_WIN : ST_P1_WIN;
          winner_d = player_q ? WIN_P2 : WIN_P1;
          hold_d   = {HOLDW{1'b0}};
        end else if (dir_q == DIR_A) begin
          if (move_cnt_q == CNT_FULL) begin
            state_d  = ST_TIE;
            winner_d = WIN_TIE;
            hold_d   = {HOLDW{1'b0}};
          end else begin
            player_d = ~player_q;
            state_d  = ST_PLAY;
          end
        end else begin
          dir_d = dir_e'(dir_q + 2'd1);
        end
      end
      ST_P1_WIN, ST_P2_WIN, ST_TIE: begin
        if (hold_q >= HOLD_LAST) begin
          state_d = ST_CLEAR;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_CLEAR: begin
        board_d    = {(2*CELLS){1'b0}};
        move_cnt_d = {CNTW{1'b0}};
        player_d   = 1'b0;
        winner_d   = WIN_NONE;
        hold_d     = {HOLDW{1'b0}};
        dir_d      = DIR_H;
        state_d    = ST_PLAY;
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      board_q    <= {(2*CELLS){1'b0}};
      loc_q      <= {CELLS{1'b0}};
      loc_idx_q  <= {IDXW{1'b0}};
      player_q   <= 1'b0;
      move_cnt_q <= {CNTW{1'b0}};
      hold_q     <= {HOLDW{1'b0}};
      dir_q      <= DIR_H;
      winner_q   <= WIN_NONE;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      loc_q      <= loc_d;
      loc_idx_q  <= loc_idx_d;
      player_q   <= player_d;
      move_cnt_q <= move_cnt_d;
      hold_q     <= hold_d;
      dir_q      <= dir_d;
      winner_q   <= winner_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign board_o    = board_q;
  assign cur_player = player_q;
  assign state_o    = state_q;
  assign winner_o   = winner_q;
  assign move_ok    = ok_q;
  assign move_err   = err_q;

endmodule

// File: tb/tb_mnk_game.sv
// Scoreboard bench for mnk_game: a 3x3 K=3 instance and a 5x5 K=4 instance
// driven with directed move sequences; a monitor checks each pulse and result entry.
module tb_mnk_game;

  localparam int HOLD = 4;
  localparam logic [2:0] S_PLAY = 3'd0, S_CM = 3'd1, S_CW = 3'd2, S_P1 = 3'd3,
                         S_P2 = 3'd4, S_TIE = 3'd5, S_CLR = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, sel_a, pl_a, ok_a, err_a;
  logic [8:0]  mv_a;
  logic [17:0] brd_a;
  logic [2:0]  st_a;
  logic [1:0]  win_a;
  logic        rst_b, sel_b, pl_b, ok_b, err_b;
  logic [24:0] mv_b;
  logic [49:0] brd_b;
  logic [2:0]  st_b;
  logic [1:0]  win_b;

  mnk_game #(.N(3), .K(3), .HOLD_CYCLES(HOLD)) dut_a (
    .clk(clk), .rst(rst_a), .select(sel_a), .move(mv_a), .board_o(brd_a),
    .cur_player(pl_a), .state_o(st_a), .winner_o(win_a), .move_ok(ok_a), .move_err(err_a));

  mnk_game #(.N(5), .K(4), .HOLD_CYCLES(HOLD)) dut_b (
    .clk(clk), .rst(rst_b), .select(sel_b), .move(mv_b), .board_o(brd_b),
    .cur_player(pl_b), .state_o(st_b), .winner_o(win_b), .move_ok(ok_b), .move_err(err_b));

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] board;
    logic        player;
    logic [2:0]  state;
    logic [1:0]  winner;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] mb_a = 64'd0, mb_b = 64'd0;
  logic        mp_a = 1'b0, mp_b = 1'b0;
  logic [2:0]  prev_a = 3'd0, prev_b = 3'd0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] get_state(input int id);
    return (id == 0) ? st_a : st_b;
  endfunction

  task automatic pop_cmp(input int id, input logic [1:0] kind);
    exp_t        e;
    logic [63:0] brd;
    logic        pl;
    logic [2:0]  st;
    logic [1:0]  w;
    int          sz;
    brd = (id == 0) ? 64'(brd_a) : 64'(brd_b);
    pl  = (id == 0) ? pl_a : pl_b;
    st  = get_state(id);
    w   = (id == 0) ? win_a : win_b;
    sz  = (id == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected dut%0d: got event kind %0d expected none", id, kind);
    end else begin
      e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
      chk("sb_kind", 64'(kind), 64'(e.kind));
      chk("sb_board", brd, e.board);
      chk("sb_player", 64'(pl), 64'(e.player));
      if (e.kind == 2'd2) begin
        chk("sb_state", 64'(st), 64'(e.state));
        chk("sb_winner", 64'(w), 64'(e.winner));
      end
    end
  endtask

  // Monitors: pop an expectation on every ok/err pulse and on entry to a result state.
  always @(negedge clk) begin
    if (rst_a == 1'b0) begin
      if (ok_a)  pop_cmp(0, 2'd0);
      if (err_a) pop_cmp(0, 2'd1);
      if (st_a != prev_a && (st_a == S_P1 || st_a == S_P2 || st_a == S_TIE)) pop_cmp(0, 2'd2);
    end
    prev_a <= st_a;
  end

  always @(negedge clk) begin
    if (rst_b == 1'b0) begin
      if (ok_b)  pop_cmp(1, 2'd0);
      if (err_b) pop_cmp(1, 2'd1);
      if (st_b != prev_b && (st_b == S_P1 || st_b == S_P2 || st_b == S_TIE)) pop_cmp(1, 2'd2);
    end
    prev_b <= st_b;
  end

  task automatic wait_state(input int id, input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (get_state(id) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(get_state(id)), 64'(st));
  endtask

  task automatic submit(input int id, input logic [63:0] mv, input bit ok, input logic [2:0] end_st);
    exp_t        e;
    logic [63:0] brd;
    logic        pl;
    int          idx;
    wait_state(id, S_PLAY, 40, "wait_play");
    brd = (id == 0) ? mb_a : mb_b;
    pl  = (id == 0) ? mp_a : mp_b;
    if (ok) begin
      idx = 0;
      for (int i = 0; i < 64; i++) if (mv[i]) idx = i;
      brd[2*idx +: 2] = pl ? 2'b10 : 2'b01;
    end
    e = '{kind: (ok ? 2'd0 : 2'd1), board: brd, player: pl, state: 3'd0, winner: 2'd0};
    if (id == 0) q_a.push_back(e); else q_b.push_back(e);
    if (end_st != 3'd0) begin
      e.kind   = 2'd2;
      e.state  = end_st;
      e.winner = (end_st == S_P1) ? 2'b01 : (end_st == S_P2) ? 2'b10 : 2'b11;
      if (id == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    if (ok && end_st == 3'd0) pl = ~pl;
    if (id == 0) begin mb_a = brd; mp_a = pl; sel_a = 1'b1; mv_a = mv[8:0]; end
    else         begin mb_b = brd; mp_b = pl; sel_b = 1'b1; mv_b = mv[24:0]; end
    @(negedge clk);
    if (id == 0) begin sel_a = 1'b0; mv_a = 9'd0; end
    else         begin sel_b = 1'b0; mv_b = 25'd0; end
  endtask

  task automatic chk_reset(input int id, input string name);
    if (id == 0) begin
      chk({name, "_board"}, 64'(brd_a), 64'd0);
      chk({name, "_player"}, 64'(pl_a), 64'd0);
      chk({name, "_state"}, 64'(st_a), 64'(S_PLAY));
      chk({name, "_winner"}, 64'(win_a), 64'd0);
      chk({name, "_okerr"}, 64'({ok_a, err_a}), 64'd0);
      chk({name, "_cnt"}, 64'(dut_a.move_cnt_q), 64'd0);
      chk({name, "_hold"}, 64'(dut_a.hold_q), 64'd0);
    end else begin
      chk({name, "_board"}, 64'(brd_b), 64'd0);
      chk({name, "_player"}, 64'(pl_b), 64'd0);
      chk({name, "_state"}, 64'(st_b), 64'(S_PLAY));
      chk({name, "_winner"}, 64'(win_b), 64'd0);
      chk({name, "_okerr"}, 64'({ok_b, err_b}), 64'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int s4 [8]   = '{4, 20, 5, 16, 6, 12, 7, 8};

    rst_a = 1'b1; sel_a = 1'b1; mv_a = 9'd1;
    rst_b = 1'b1; sel_b = 1'b1; mv_b = 25'd1;
    repeat (2) @(negedge clk);
    chk_reset(0, "rst_a");
    chk_reset(1, "rst_b");
    rst_a = 1'b0; sel_a = 1'b0; mv_a = 9'd0;
    rst_b = 1'b0; sel_b = 1'b0; mv_b = 25'd0;
    @(negedge clk);
    chk("post_rst_play_a", 64'(st_a), 64'(S_PLAY));

    // Scenario 1: P1 takes the top row.
    submit(0, 64'd1 << 0, 1'b1, 3'd0);
    submit(0, 64'd1 << 3, 1'b1, 3'd0);
    submit(0, 64'd1 << 1, 1'b1, 3'd0);
    submit(0, 64'd1 << 4, 1'b1, 3'd0);
    submit(0, 64'd1 << 2, 1'b1, S_P1);
    wait_state(0, S_P1, 10, "s1_enter_win");
    n = 0;
    while (st_a == S_P1 && n < 50) begin
      chk("s1_win_held", 64'(win_a), 64'd1);
      @(negedge clk);
      n++;
    end
    chk("s1_hold_len", 64'(n), 64'(HOLD));
    chk("s1_clear", 64'(st_a), 64'(S_CLR));
    @(negedge clk);
    chk("s1_play", 64'(st_a), 64'(S_PLAY));
    chk("s1_board_clr", 64'(brd_a), 64'd0);
    chk("s1_winner_clr", 64'(win_a), 64'd0);
    chk("s1_player_clr", 64'(pl_a), 64'd0);
    chk("s1_cnt_clr", 64'(dut_a.move_cnt_q), 64'd0);
    mb_a = 64'd0; mp_a = 1'b0;

    // Scenario 2: occupied, zero-hot and multi-hot moves are rejected.
    submit(0, 64'd1 << 4, 1'b1, 3'd0);
    submit(0, 64'd1 << 4, 1'b0, 3'd0);
    submit(0, 64'd0,      1'b0, 3'd0);
    submit(0, 64'h3,      1'b0, 3'd0);
    submit(0, 64'd1 << 0, 1'b1, 3'd0);
    wait_state(0, S_PLAY, 10, "s2_settle");

    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; mb_a = 64'd0; mp_a = 1'b0;
    chk_reset(0, "s2_rst");

    // Scenario 3: nine-move draw.
    for (int i = 0; i < 9; i++) submit(0, 64'd1 << draw[i], 1'b1, (i == 8) ? S_TIE : 3'd0);
    wait_state(0, S_TIE, 10, "s3_tie");
    chk("s3_winner", 64'(win_a), 64'h3);
    chk("s3_cnt", 64'(dut_a.move_cnt_q), 64'd9);
    @(negedge clk);
    @(negedge clk);
    chk("s3_hold_mid", 64'(st_a), 64'(S_TIE));
    rst_a = 1'b1;
    @(negedge clk);
    chk_reset(0, "s5_rst_hold");
    rst_a = 1'b0; mb_a = 64'd0; mp_a = 1'b0;

    // Scenario 5: reset in the second CHECK_WIN cycle, with select asserted alongside.
    submit(0, 64'd1 << 4, 1'b1, 3'd0);
    wait_state(0, S_CW, 5, "s5_cw1");
    @(negedge clk);
    chk("s5_cw2_state", 64'(st_a), 64'(S_CW));
    chk("s5_cw2_dir", 64'(dut_a.dir_q), 64'd1);
    rst_a = 1'b1; sel_a = 1'b1; mv_a = 9'h001;
    @(negedge clk);
    chk_reset(0, "s5_rst_cw");
    rst_a = 1'b0; sel_a = 1'b0; mv_a = 9'd0; mb_a = 64'd0; mp_a = 1'b0;
    @(negedge clk);
    chk("s5_sel_ignored", 64'(st_a), 64'(S_PLAY));

    // Scenario 4: 5x5 K=4, row-wrapping P1 run must not win; P2 anti-diagonal wins.
    for (int i = 0; i < 8; i++) submit(1, 64'd1 << s4[i], 1'b1, (i == 7) ? S_P2 : 3'd0);
    wait_state(1, S_P2, 10, "s4_p2_win");
    chk("s4_winner", 64'(win_b), 64'h2);
    wait_state(1, S_CLR, 10, "s4_clear");
    wait_state(1, S_PLAY, 5, "s4_play");
    chk("s4_board_clr", 64'(brd_b), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain_a", 64'(q_a.size()), 64'd0);
    chk("sb_drain_b", 64'(q_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
